// File: rtl/custom_reg_arb_pkg.sv
// Shared types, defaults and helpers for the custom register bank arbiter.
package custom_reg_arb_pkg;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefNumRegs   = 3;
    localparam int unsigned DefDataWidth = 32;

    // Field widths of the response register. They are upper bounds, and the
    // top level zero-extends into these fields.
    localparam int unsigned RespIdxW  = 8;
    localparam int unsigned RespAddrW = 8;
    localparam int unsigned RespDataW = 64;

    typedef struct packed {
        logic                 valid;
        logic [RespIdxW-1:0]  idx;
        logic                 we;
        logic [RespAddrW-1:0] addr;
        logic [RespDataW-1:0] data;
        logic                 err;
    } resp_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clamp_clog2(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/custom_reg_arbiter_rr_arb.sv
// Generic round-robin arbiter: one-hot grant plus encoded winner index.
module custom_reg_rr_arb
    import custom_reg_arb_pkg::*;
#(
    parameter int unsigned NumReq = DefNumReq,
    parameter int unsigned IdxW   = clamp_clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    // Search upward from the pointer with wrap-around; the first requester wins.
    always_comb begin
        int unsigned     cand_w;
        logic [IdxW-1:0] cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_w  = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand_w = (32'(ptr_q) + i) % NumReq;
            cand   = IdxW'(cand_w);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    // Move the pointer just past the winner; hold it when nobody requests.
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + IdxW'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/custom_reg_arbiter.sv
// Shares the custom register bank between several register-bus requesters.
// One access per cycle, with the response and the bank write strobe one cycle
// after the grant.
module custom_reg_arbiter
    import custom_reg_arb_pkg::*;
#(
    parameter int unsigned NumReq    = DefNumReq,
    parameter int unsigned NumRegs   = DefNumRegs,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AddrW     = clamp_clog2(NumRegs)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0]            we_i,
    input  logic [NumReq*AddrW-1:0]      addr_i,
    input  logic [NumReq*DataWidth-1:0]  wdata_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [NumReq-1:0]            rvalid_o,
    output logic [DataWidth-1:0]         rdata_o,
    output logic                         err_o,
    output logic [NumRegs-1:0]           reg_de_o,
    output logic [NumRegs*DataWidth-1:0] reg_q_o,
    input  logic [NumRegs*DataWidth-1:0] reg_d_i
);

    localparam int unsigned IdxW = clamp_clog2(NumReq);

    logic [NumReq-1:0]    req_live;
    logic [IdxW-1:0]      win_idx;
    logic                 win_valid;
    logic                 win_we;
    logic [AddrW-1:0]     win_addr;
    logic [DataWidth-1:0] win_wdata;
    logic                 addr_ok;
    logic [DataWidth-1:0] bank_rdata;
    resp_t                resp_q, resp_d;
    logic                 unused_resp;

    // Requests are masked while reset is held so that no grant is shown in reset.
    assign req_live = req_i & {NumReq{rst_ni}};

    custom_reg_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_live),
        .gnt_o   (gnt_o),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Mux the winning requester's fields and read the addressed bank register.
    always_comb begin
        win_we     = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        bank_rdata = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (gnt_o[k]) begin
                win_we    = we_i[k];
                win_addr  = addr_i[k*AddrW +: AddrW];
                win_wdata = wdata_i[k*DataWidth +: DataWidth];
            end
        end
        addr_ok = 32'(win_addr) < NumRegs;
        for (int unsigned r = 0; r < NumRegs; r++) begin
            if (32'(win_addr) == r) begin
                bank_rdata = reg_d_i[r*DataWidth +: DataWidth];
            end
        end
    end

    // Build the next response. A write in its response stage has not reached
    // reg_d_i yet, so a read of the same register takes the write data instead.
    always_comb begin
        resp_d = '0;
        if (win_valid) begin
            resp_d.valid = 1'b1;
            resp_d.idx   = RespIdxW'(win_idx);
            resp_d.we    = win_we;
            resp_d.addr  = RespAddrW'(win_addr);
            resp_d.err   = !addr_ok;
            if (addr_ok) begin
                if (win_we) begin
                    resp_d.data = RespDataW'(win_wdata);
                end else if (resp_q.valid && resp_q.we && !resp_q.err &&
                             resp_q.addr == RespAddrW'(win_addr)) begin
                    resp_d.data = resp_q.data;
                end else begin
                    resp_d.data = RespDataW'(bank_rdata);
                end
            end
        end
    end

    // One-deep response register; reset discards any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Decode the response register into the requester response and bank strobes.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = 1'b0;
        reg_de_o = '0;
        reg_q_o  = '0;
        if (resp_q.valid) begin
            rdata_o = resp_q.data[DataWidth-1:0];
            err_o   = resp_q.err;
            for (int unsigned k = 0; k < NumReq; k++) begin
                if (resp_q.idx == RespIdxW'(k)) begin
                    rvalid_o[k] = 1'b1;
                end
            end
            if (resp_q.we && !resp_q.err) begin
                for (int unsigned r = 0; r < NumRegs; r++) begin
                    if (resp_q.addr == RespAddrW'(r)) begin
                        reg_de_o[r]                       = 1'b1;
                        reg_q_o[r*DataWidth +: DataWidth] = resp_q.data[DataWidth-1:0];
                    end
                end
            end
        end
    end

    // The response fields are wider than this configuration needs.
    assign unused_resp = ^resp_q;

endmodule

// File: doc/custom_reg_arbiter.md
Name: custom_reg_arbiter

Overview:
- Shares the custom register bank between NumReq simple register-bus requesters (cores, DMA, debug).
- Arbitrates round-robin and issues at most one access per cycle.
- Drives per-register write strobes and write data into the bank, and returns read data and error status to the winning requester.
- Sits between the requester ports and the bank's reg2hw/hw2reg write-enable/data interface.

Parameters:
- NumReq, 4, number of requesters (>=2)
- NumRegs, 3, number of 32-bit registers in the bank
- DataWidth, 32, register and data width
- AddrW, $clog2(NumRegs) (min 1), derived, register index width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_i  in  NumReq  per-requester request, held until granted
- we_i  in  NumReq  1=write, 0=read
- addr_i  in  NumReq*AddrW  register index per requester
- wdata_i  in  NumReq*DataWidth  write data per requester
- gnt_o  out  NumReq  one-hot grant, combinational from req_i and the priority pointer
- rvalid_o  out  NumReq  one-hot response pulse
- rdata_o  out  DataWidth  response data, shared, valid with rvalid_o
- err_o  out  1  response error, valid with rvalid_o
- reg_de_o  out  NumRegs  per-register write strobe to the bank
- reg_q_o  out  NumRegs*DataWidth  per-register write data to the bank
- reg_d_i  in  NumRegs*DataWidth  current register values from the bank

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, reg_de_o=0, reg_q_o=0, priority pointer=0, response stage empty.
- Arbitration:
  - Round-robin. Priority starts at requester ptr and ascends with wrap-around (NumReq-1 -> 0).
  - Exactly one gnt_o bit is set whenever any req_i bit is set; gnt_o=0 when req_i=0.
- Pointer update: on a grant to requester k, ptr <= (k+1) mod NumReq on the next edge. No request leaves ptr unchanged.
- Handshake: a transaction is accepted in the cycle where req_i[k]&gnt_o[k]. The requester may change or drop its request the next cycle. Back-to-back grants are allowed, giving one access per cycle.
- Response timing: latency is 1 cycle. In the cycle after the grant:
  - rvalid_o[k]=1 for exactly one cycle.
  - reg_de_o/reg_q_o are driven in that same cycle for writes.
- Write to a valid addr a:
  - Response cycle: reg_de_o[a]=1 and reg_q_o[a]=wdata.
  - All other de bits are 0.
  - rdata_o=wdata, err_o=0.
- Read from a valid addr a: rdata_o = reg_d_i[a] sampled at the grant edge, err_o=0, reg_de_o=0.
- Write-then-read hazard:
  - Case: a read of addr a is granted in the same cycle that a write to a is in its response stage (de asserting).
  - Required: the read returns the write data (forwarding), not the stale reg_d_i.
- Invalid address (addr >= NumRegs, possible when NumRegs is not a power of two):
  - The request is still granted.
  - Response: err_o=1, rdata_o=0, no reg_de_o.
  - The pointer advances normally.
- Idle outputs: reg_de_o is 0 in every cycle without a valid write response. rdata_o and err_o are 0 when rvalid_o=0.
- Simultaneous requests: all requesters are served within NumReq consecutive grants; no starvation.
- Reset mid-operation: a pending response is discarded (no rvalid_o, no reg_de_o after reset assertion), and ptr returns to 0.
- No state machine beyond the priority pointer and a one-deep response register containing: valid, winner index, we, addr, data, err.

Decomposition:
- Package custom_reg_arb_pkg holds:
  - the resp_t struct (valid, idx, we, addr, data, err)
  - a function for the clamped index width (max(1,$clog2(n)))
  - default parameter constants
- Sub-module custom_reg_rr_arb: a generic round-robin arbiter (req in, ptr update, one-hot gnt plus encoded index out), reusable elsewhere.
- The top level keeps the request mux, response register, forwarding and bank strobe decode.

Test Plan:
- Reset, then single write: req_i=0001, we=1, addr=1, wdata=32'hDEADBEEF -> gnt_o=0001 same cycle; next cycle reg_de_o=010, reg_q_o[1]=DEADBEEF, rvalid_o=0001, err_o=0.
- Read after write (forwarding): write 32'h1234 to addr 2 by req 0, then next cycle a read of addr 2 by req 1 -> second response rdata_o=32'h1234.
- Fairness: req_i=1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, with one rvalid_o per cycle in the same order, delayed by 1 cycle.
- Invalid address with NumRegs=3: read of addr 3 -> gnt same cycle; next cycle err_o=1, rdata_o=0, reg_de_o=000; ptr advances.
- Idle pointer hold: grant req 2, then 3 idle cycles, then req_i=1111 -> gnt_o=1000.
- Reset mid-operation: assert rst_ni=0 in the cycle after a write grant -> reg_de_o=0 and rvalid_o=0 immediately, and the bank register is unchanged.
